// File: rtl/tt_alu_seq.sv
// Sequential ALU: ADD/SUB/XOR complete in one cycle; MUL is an iterative shift-add.
// An RW-bit accumulator can receive results and feed operand A back in.
// Build option: define TT_ALU_MUL_EN to include the multiplier. Without it, MUL returns err=1 and result=0 after one cycle.
module tt_alu_seq #(
   parameter  int WIDTH = 4,
   localparam int RW    = 2*WIDTH+2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       opcode,
   input  logic [1:0]       inmode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [RW-1:0]    result,
   output logic             err
);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_XOR = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [RW-1:0]    acc;
   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [RW-1:0]    quick_res;
   logic             quick_err;
   logic             unused_acc_hi;

   assign accept = in_valid & in_ready;
   // Chained operations take operand A from the low bits of the accumulator.
   assign op_a   = inmode[0] ? acc[WIDTH-1:0] : a;

   // Only the low WIDTH bits of acc feed back into the datapath.
   assign unused_acc_hi = ^acc[RW-1:WIDTH];

`ifdef TT_ALU_MUL_EN
   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

   logic [RW-1:0]    mcand;
   logic [RW-1:0]    prod;
   logic [RW-1:0]    mul_sum;
   logic [WIDTH-1:0] mplier;
   logic [CW-1:0]    cnt;
   logic             mul_acc_wr;

   // Each BUSY cycle consumes one multiplier bit, from the LSB upward.
   assign mul_sum = prod + (mplier[0] ? mcand : '0);
`endif

   // Single-cycle operations are computed directly from the live inputs at accept.
   always_comb begin
      // NOTE: default every output first so that no case path can infer a latch.
      quick_res = '0;
      quick_err = 1'b0;
      case (opcode)
         OP_ADD: quick_res = RW'(op_a) + RW'(b);
         OP_SUB: quick_res = RW'(op_a) - RW'(b);
         OP_XOR: quick_res = RW'(op_a ^ b);
         OP_MUL: quick_err = 1'b1;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments, so every branch reads pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         acc       <= '0;
         result    <= '0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
`ifdef TT_ALU_MUL_EN
         mcand      <= '0;
         prod       <= '0;
         mplier     <= '0;
         cnt        <= '0;
         mul_acc_wr <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  in_ready <= 1'b0;
`ifdef TT_ALU_MUL_EN
                  if (opcode == OP_MUL) begin
                     state      <= BUSY;
                     mcand      <= RW'(op_a);
                     mplier     <= b;
                     prod       <= '0;
                     cnt        <= '0;
                     mul_acc_wr <= inmode[1];
                  end else
`endif
                  begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= quick_res;
                     err       <= quick_err;
                     if (inmode[1] && !quick_err) begin
                        acc <= quick_res;
                     end
                  end
               end
            end
`ifdef TT_ALU_MUL_EN
            BUSY: begin
               prod   <= mul_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= mul_sum;
                  err       <= 1'b0;
                  if (mul_acc_wr) begin
                     acc <= mul_sum;
                  end
               end
            end
`endif
            DONE: begin
               // in_ready rises only after the consume edge, so no request overlaps the result hand-off.
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tt_alu_seq.sv
// Self-checking bench for tt_alu_seq (WIDTH=4). It uses directed spec cases plus randomized traffic against an arithmetic model.
// Compile with or without TT_ALU_MUL_EN to match the RTL build.
module tb_tt_alu_seq;

   localparam int W  = 4;
   localparam int RW = 2*W+2;
`ifdef TT_ALU_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [1:0]    opcode;
   logic [1:0]    inmode;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] result;
   logic          err;

   int     checks = 0;
   int     errors = 0;
   longint acc_m  = 0;

   tt_alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .inmode    (inmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model: plain arithmetic on the operation. It also advances the model accumulator.
   function automatic void model(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [1:0] mode, output logic [RW-1:0] r, output logic e,
                                 output int lat);
      longint x, y, full;
      x    = mode[0] ? (acc_m & ((64'sd1 << W) - 1)) : longint'(av);
      y    = longint'(bv);
      e    = 1'b0;
      lat  = 1;
      full = 0;
      case (op)
         2'd0: full = x + y;
         2'd1: full = x - y;
         2'd2: begin
            if (MUL_EN) begin
               full = x * y;
               lat  = W + 1;
            end else begin
               e = 1'b1;
            end
         end
         default: full = x ^ y;
      endcase
      r = full[RW-1:0];
      if (mode[1] && !e) acc_m = longint'(r);
   endfunction

   // Issue one request from a negedge. Wait for the result, hold it for 'hold' cycles, then consume it.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [1:0] mode, input int hold, input bit early,
                         output logic [RW-1:0] r, output logic e, output int lat, output bit to);
      int n;
      to  = 1'b0;
      lat = 0;
      r   = '0;
      e   = 1'b0;
      n   = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         to = 1'b1;
         return;
      end
      in_valid = 1'b1;
      opcode   = op;
      a        = av;
      b        = bv;
      inmode   = mode;
      @(negedge clk);
      in_valid  = 1'b0;
      a         = W'($urandom);
      b         = W'($urandom);
      opcode    = 2'($urandom);
      inmode    = 2'($urandom);
      out_ready = early;
      lat       = 1;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      if (!out_valid) begin
         to        = 1'b1;
         out_ready = 1'b0;
         return;
      end
      r         = result;
      e         = err;
      out_ready = 1'b0;
      repeat (hold) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      logic [RW-1:0] r;
      logic          e;
      int            lat;
      bit            to;
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; opcode = '0; inmode = '0;
      #1 rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || err !== 1'b0 || dut.acc !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h err=%b acc=%h, want 1 0 000 0 000",
                  in_ready, out_valid, result, err, dut.acc);
      end
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      acc_m = 0;
      run_op(2'd0, 4'd1, 4'd2, 2'b00, 0, 1'b0, r, e, lat, to);
      checks++;
      if (to || lat !== 1 || r !== 10'h003 || e !== 1'b0) begin
         errors++;
         $display("FAIL first_accept: to=%0d lat=%0d result=%h err=%b, want lat=1 result=003 err=0", to, lat, r, e);
      end
   endtask

   task automatic test_directed();
      logic [RW-1:0] r, mr;
      logic          e, me;
      int            lat, ml;
      bit            to;
      model(2'd0, 4'hF, 4'hF, 2'b00, mr, me, ml);
      run_op(2'd0, 4'hF, 4'hF, 2'b00, 0, 1'b0, r, e, lat, to);
      checks++;
      if (to || lat !== 1 || r !== 10'h01E || e !== 1'b0) begin
         errors++;
         $display("FAIL add_15_15: lat=%0d result=%h err=%b, want lat=1 result=01e err=0", lat, r, e);
      end
      model(2'd1, 4'd3, 4'd5, 2'b00, mr, me, ml);
      run_op(2'd1, 4'd3, 4'd5, 2'b00, 1, 1'b0, r, e, lat, to);
      checks++;
      if (to || lat !== 1 || r !== 10'h3FE || e !== 1'b0) begin
         errors++;
         $display("FAIL sub_3_5: lat=%0d result=%h err=%b, want lat=1 result=3fe err=0", lat, r, e);
      end
      model(2'd3, 4'hA, 4'h6, 2'b00, mr, me, ml);
      run_op(2'd3, 4'hA, 4'h6, 2'b00, 0, 1'b1, r, e, lat, to);
      checks++;
      if (to || lat !== 1 || r !== 10'h00C || e !== 1'b0) begin
         errors++;
         $display("FAIL xor_a_6: lat=%0d result=%h err=%b, want lat=1 result=00c err=0", lat, r, e);
      end
   endtask

   task automatic test_mul();
      logic [RW-1:0] mr, want_r;
      logic          me;
      int            ml, lat, busy_lo, want_busy;
      want_r    = MUL_EN ? 10'h0E1 : 10'h000;
      want_busy = MUL_EN ? W : 0;
      model(2'd2, 4'hF, 4'hF, 2'b00, mr, me, ml);
      in_valid = 1'b1; opcode = 2'd2; a = 4'hF; b = 4'hF; inmode = 2'b00;
      @(negedge clk);
      in_valid = 1'b0; a = '0; b = '0; opcode = 2'd0;
      lat      = 1;
      busy_lo  = 0;
      while (!out_valid && lat < 50) begin
         if (!in_ready) busy_lo++;
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat !== ml || busy_lo !== want_busy) begin
         errors++;
         $display("FAIL mul_timing: lat=%0d busy_cycles=%0d, want lat=%0d busy_cycles=%0d", lat, busy_lo, ml, want_busy);
      end
      checks++;
      if (result !== want_r || err !== !MUL_EN || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mul_15_15: result=%h err=%b in_ready=%b, want result=%h err=%b in_ready=0",
                  result, err, in_ready, want_r, !MUL_EN);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_hold();
      logic [RW-1:0] mr;
      logic          me;
      int            ml;
      model(2'd0, 4'd2, 4'd3, 2'b00, mr, me, ml);
      in_valid = 1'b1; opcode = 2'd0; a = 4'd2; b = 4'd3; inmode = 2'b00;
      @(negedge clk);
      a = 4'd9; b = 4'd9; opcode = 2'd3;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (out_valid !== 1'b1 || result !== 10'h005 || err !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_cycle%0d: out_valid=%b result=%h err=%b in_ready=%b, want 1 005 0 0",
                     i, out_valid, result, err, in_ready);
         end
         if (i == 3) out_ready = 1'b1;
         @(negedge clk);
      end
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL hold_release: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL no_accept_on_consume: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_accumulate();
      logic [RW-1:0] r, mr;
      logic          e, me;
      int            lat, ml;
      bit            to;
      model(2'd0, 4'd4, 4'd1, 2'b10, mr, me, ml);
      run_op(2'd0, 4'd4, 4'd1, 2'b10, 0, 1'b0, r, e, lat, to);
      checks++;
      if (to || r !== 10'h005 || dut.acc !== 10'h005) begin
         errors++;
         $display("FAIL acc_load: result=%h acc=%h, want 005 005", r, dut.acc);
      end
      model(2'd0, 4'd0, 4'd2, 2'b11, mr, me, ml);
      run_op(2'd0, 4'd0, 4'd2, 2'b11, 0, 1'b0, r, e, lat, to);
      checks++;
      if (to || r !== 10'h007 || dut.acc !== 10'h007) begin
         errors++;
         $display("FAIL acc_chain: result=%h acc=%h, want 007 007", r, dut.acc);
      end
      model(2'd1, 4'd0, 4'd9, 2'b01, mr, me, ml);
      run_op(2'd1, 4'd0, 4'd9, 2'b01, 0, 1'b0, r, e, lat, to);
      checks++;
      if (to || r !== 10'h3FE || dut.acc !== 10'h007) begin
         errors++;
         $display("FAIL acc_read_only: result=%h acc=%h, want 3fe 007", r, dut.acc);
      end
   endtask

   task automatic test_random();
      logic [RW-1:0] r, mr;
      logic          e, me;
      logic [1:0]    op, mode;
      logic [W-1:0]  av, bv;
      int            lat, ml, hold;
      bit            to, early;
      for (int i = 0; i < 60; i++) begin
         op    = 2'($urandom);
         mode  = 2'($urandom);
         av    = W'($urandom);
         bv    = W'($urandom);
         hold  = int'($urandom_range(0, 2));
         early = (hold == 0) ? 1'($urandom) : 1'b0;
         model(op, av, bv, mode, mr, me, ml);
         run_op(op, av, bv, mode, hold, early, r, e, lat, to);
         checks++;
         if (to || r !== mr || e !== me || lat !== ml || dut.acc !== acc_m[RW-1:0]) begin
            errors++;
            $display("FAIL random%0d op=%0d a=%h b=%h mode=%b: to=%0d result=%h err=%b lat=%0d acc=%h, want result=%h err=%b lat=%0d acc=%h",
                     i, op, av, bv, mode, to, r, e, lat, dut.acc, mr, me, ml, acc_m[RW-1:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] r, mr;
      logic          e, me;
      int            lat, ml;
      bit            to;
      for (int i = 0; i < 4; i++) begin
         model(2'd0, W'(i), W'(i + 1), 2'b00, mr, me, ml);
         run_op(2'd0, W'(i), W'(i + 1), 2'b00, 0, 1'b1, r, e, lat, to);
         checks++;
         if (to || r !== mr || lat !== 1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back%0d: result=%h lat=%0d in_ready=%b, want %h 1 1", i, r, lat, in_ready, mr);
         end
      end
   endtask

   task automatic test_mul_abort();
      logic [RW-1:0] r, mr;
      logic          e, me;
      int            lat, ml, seen;
      bit            to;
      model(2'd0, 4'd3, 4'd4, 2'b10, mr, me, ml);
      run_op(2'd0, 4'd3, 4'd4, 2'b10, 0, 1'b0, r, e, lat, to);
      checks++;
      if (to || dut.acc !== 10'h007) begin
         errors++;
         $display("FAIL abort_preload: acc=%h, want 007", dut.acc);
      end
      in_valid = 1'b1; opcode = 2'd2; a = 4'hF; b = 4'hF; inmode = 2'b10;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || dut.acc !== '0 || result !== '0 || err !== 1'b0) begin
         errors++;
         $display("FAIL abort_reset: out_valid=%b in_ready=%b acc=%h result=%h err=%b, want 0 1 000 000 0",
                  out_valid, in_ready, dut.acc, result, err);
      end
      @(negedge clk);
      rst   = 1'b0;
      acc_m = 0;
      seen  = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      checks++;
      if (seen !== 0 || in_ready !== 1'b1 || dut.acc !== '0) begin
         errors++;
         $display("FAIL abort_quiet: out_valid_cycles=%0d in_ready=%b acc=%h, want 0 1 000", seen, in_ready, dut.acc);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_mul();
      test_hold();
      test_accumulate();
      test_back_to_back();
      test_random();
      test_mul_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete within time limit");
      $fatal(1, "timeout");
   end

endmodule
